// File: rtl/q_sys_pll_status_sequencer.sv
// PLL power/lock sequencer: PWRDN -> MCGB_RST -> WAIT_LOCK -> LOCKED with a lock filter and sticky loss flag.
// Define Q_SYS_PLL_LOCK_LOSS_CNT_EN to build the saturating lock-loss event counter; otherwise lock_loss_count is 0.
module q_sys_pll_status_sequencer #(
    parameter int NUM_CONSUMERS      = 2,
    parameter int LOCK_FILTER_CYCLES = 256,
    parameter int MCGB_RST_CYCLES    = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     pll_locked,
    input  logic [NUM_CONSUMERS-1:0] pll_powerdown_req,
    output logic                     pll_powerdown,
    output logic                     mcgb_rst,
    output logic                     pll_locked_output,
    output logic [NUM_CONSUMERS-1:0] pll_locked_fanout,
    output logic                     lock_lost_sticky,
    input  logic                     lock_lost_clr,
    output logic [15:0]              lock_loss_count
);

    typedef enum logic [1:0] {PWRDN, MCGB_RST, WAIT_LOCK, LOCKED} state_t;

    localparam logic [15:0] FILT_LAST = 16'(LOCK_FILTER_CYCLES - 1);
    localparam logic [7:0]  MCGB_LAST = 8'(MCGB_RST_CYCLES - 1);

    state_t      state_q, state_d;
    logic [1:0]  sync_q;
    logic [15:0] filt_q, filt_d;
    logic [7:0]  mcgb_cnt_q, mcgb_cnt_d;
    logic        pd_q, mcgb_rst_q, locked_q, sticky_q;
    logic        lock_s, req_any, loss_evt;

    assign lock_s  = sync_q[1];
    assign req_any = |pll_powerdown_req;

    always_comb begin
        state_d    = state_q;
        filt_d     = filt_q;
        mcgb_cnt_d = mcgb_cnt_q;
        loss_evt   = 1'b0;
        case (state_q)
            PWRDN: begin
                if (!req_any) begin
                    state_d    = MCGB_RST;
                    mcgb_cnt_d = '0;
                end
            end
            MCGB_RST: begin
                if (mcgb_cnt_q == MCGB_LAST) begin
                    state_d    = WAIT_LOCK;
                    mcgb_cnt_d = '0;
                    filt_d     = '0;
                end else begin
                    mcgb_cnt_d = mcgb_cnt_q + 8'd1;
                end
            end
            WAIT_LOCK: begin
                if (!lock_s) begin
                    filt_d = '0;
                end else if (filt_q == FILT_LAST) begin
                    state_d = LOCKED;
                    filt_d  = '0;
                end else begin
                    filt_d = filt_q + 16'd1;
                end
            end
            LOCKED: begin
                if (!lock_s) begin
                    state_d  = WAIT_LOCK;
                    filt_d   = '0;
                    loss_evt = 1'b1;
                end
            end
            default: state_d = PWRDN;
        endcase
        // Powerdown overrides everything, but a coincident loss still flags the sticky bit.
        if (req_any) begin
            state_d    = PWRDN;
            filt_d     = '0;
            mcgb_cnt_d = '0;
        end
    end

    // Outputs are decoded from the next state so they are valid in the first cycle of each state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= PWRDN;
            sync_q     <= '0;
            filt_q     <= '0;
            mcgb_cnt_q <= '0;
            pd_q       <= 1'b1;
            mcgb_rst_q <= 1'b1;
            locked_q   <= 1'b0;
            sticky_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_q     <= {sync_q[0], pll_locked};
            filt_q     <= filt_d;
            mcgb_cnt_q <= mcgb_cnt_d;
            pd_q       <= (state_d == PWRDN);
            mcgb_rst_q <= (state_d == PWRDN) || (state_d == MCGB_RST);
            locked_q   <= (state_d == LOCKED);
            if (loss_evt)
                sticky_q <= 1'b1;
            else if (lock_lost_clr)
                sticky_q <= 1'b0;
        end
    end

`ifdef Q_SYS_PLL_LOCK_LOSS_CNT_EN
    logic [15:0] loss_cnt_q;

    // A loss that coincides with a powerdown request is treated as powerdown-induced.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            loss_cnt_q <= '0;
        else if (loss_evt && !req_any && (loss_cnt_q != 16'hFFFF))
            loss_cnt_q <= loss_cnt_q + 16'd1;
    end

    assign lock_loss_count = loss_cnt_q;
`else
    assign lock_loss_count = '0;
`endif

    assign pll_powerdown     = pd_q;
    assign mcgb_rst          = mcgb_rst_q;
    assign pll_locked_output = locked_q;
    assign pll_locked_fanout = {NUM_CONSUMERS{locked_q}};
    assign lock_lost_sticky  = sticky_q;

endmodule
